// File: rtl/depkt_pkg.sv
// Shared definitions for the multi-flit depacketizer: flit control-bit positions,
// payload field widths and the reassembly FSM state type.
package depkt_pkg;

  localparam int CTRL_BITS = 3;

  typedef enum logic [1:0] {
    DEPKT_IDLE     = 2'd0,
    DEPKT_ASSEMBLE = 2'd1,
    DEPKT_HOLD     = 2'd2
  } depkt_state_e;

  function automatic int valid_pos(input int w_pkt);
    return w_pkt - 1;
  endfunction

  function automatic int head_pos(input int w_pkt);
    return w_pkt - 2;
  endfunction

  function automatic int tail_pos(input int w_pkt);
    return w_pkt - 3;
  endfunction

  function automatic int head_pl_w(input int w_pkt, input int vc_w, input int addr_w);
    return w_pkt - CTRL_BITS - vc_w - addr_w;
  endfunction

  function automatic int body_pl_w(input int w_pkt);
    return w_pkt - CTRL_BITS;
  endfunction

  function automatic int cap_bits(input int w_pkt, input int vc_w, input int addr_w,
                                  input int n_flits);
    return head_pl_w(w_pkt, vc_w, addr_w) + (n_flits - 1) * body_pl_w(w_pkt);
  endfunction

endpackage

// File: rtl/depkt_out_reg.sv
// One-entry valid/ready holding register. empty_or_draining tells the upstream FSM
// that a new word may be loaded on the next edge without losing the current one.
module depkt_out_reg #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready_in,
  output logic         valid_out,
  output logic [W-1:0] data_out,
  output logic         empty_or_draining
);

  assign empty_or_draining = !valid_out || ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (load) begin
      valid_out <= 1'b1;
      data_out  <= load_data;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/depacketizer_n_sub.sv
// Multi-flit NoC depacketizer: strips flit control/routing fields, reassembles up to
// NUM_FLITS payloads MSB-first and hands {vc, data} to a registered valid/ready stage.
module depacketizer_n_sub
  import depkt_pkg::*;
#(
  parameter int WIDTH_PKT        = 36,
  parameter int WIDTH_DATA       = 48,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int NUM_FLITS        = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_PKT-1:0]        data_in,
  output logic                        ready_out,
  output logic [WIDTH_DATA-1:0]       data_out,
  output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        err_out
);

  localparam int HEAD_PL  = head_pl_w(WIDTH_PKT, VC_ADDRESS_WIDTH, ADDRESS_WIDTH);
  localparam int BODY_PL  = body_pl_w(WIDTH_PKT);
  localparam int CAP_BITS = cap_bits(WIDTH_PKT, VC_ADDRESS_WIDTH, ADDRESS_WIDTH, NUM_FLITS);
  localparam int IDX_W    = ($clog2(NUM_FLITS + 1) < 1) ? 1 : $clog2(NUM_FLITS + 1);
  localparam int OUT_W    = VC_ADDRESS_WIDTH + WIDTH_DATA;

  if (WIDTH_DATA > CAP_BITS) begin : g_bad_width
    $error("depacketizer_n_sub: WIDTH_DATA exceeds reassembly capacity");
  end
  if (NUM_FLITS < 1) begin : g_bad_flits
    $error("depacketizer_n_sub: NUM_FLITS must be at least 1");
  end

  depkt_state_e                state, state_n;
  logic [IDX_W-1:0]            idx, idx_n;
  logic [CAP_BITS-1:0]         assembly, asm_n, head_vec, body_vec, done_vec, ld_vec;
  logic [VC_ADDRESS_WIDTH-1:0] vc_r, vc_n, flit_vc, done_vc, ld_vc;
  logic                        flit_vld, flit_hd, flit_tl;
  logic                        err_n, done, ld, out_eod;
  logic [OUT_W-1:0]            ld_word, out_word;

  // X/Z on the valid bit must never be taken as a flit
  assign flit_vld  = (data_in[valid_pos(WIDTH_PKT)] === 1'b1);
  assign flit_hd   = data_in[head_pos(WIDTH_PKT)];
  assign flit_tl   = data_in[tail_pos(WIDTH_PKT)];
  assign flit_vc   = data_in[tail_pos(WIDTH_PKT)-1 -: VC_ADDRESS_WIDTH];
  assign ready_out = (state != DEPKT_HOLD);

  assign head_vec = CAP_BITS'(data_in[HEAD_PL-1:0]) << (CAP_BITS - HEAD_PL);

  always_comb begin
    body_vec = assembly;
    for (int k = 1; k < NUM_FLITS; k++) begin
      if (idx == IDX_W'(k))
        body_vec[CAP_BITS-1-HEAD_PL-(k-1)*BODY_PL -: BODY_PL] = data_in[BODY_PL-1:0];
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    asm_n    = assembly;
    vc_n     = vc_r;
    err_n    = 1'b0;
    done     = 1'b0;
    done_vec = head_vec;
    done_vc  = flit_vc;
    ld       = 1'b0;
    ld_vec   = assembly;
    ld_vc    = vc_r;
    case (state)
      DEPKT_IDLE, DEPKT_ASSEMBLE: begin
        if (flit_vld) begin
          if (state == DEPKT_ASSEMBLE && idx == IDX_W'(NUM_FLITS)) begin
            err_n   = 1'b1;
            state_n = DEPKT_IDLE;
            idx_n   = '0;
          end else if (flit_hd) begin
            // a head inside a packet abandons the partial one and restarts
            err_n = (state == DEPKT_ASSEMBLE);
            if (flit_tl) begin
              done = 1'b1;
            end else begin
              asm_n   = head_vec;
              vc_n    = flit_vc;
              idx_n   = IDX_W'(1);
              state_n = DEPKT_ASSEMBLE;
            end
          end else if (state == DEPKT_IDLE) begin
            err_n = 1'b1;
          end else if (flit_tl) begin
            done     = 1'b1;
            done_vec = body_vec;
            done_vc  = vc_r;
          end else begin
            asm_n = body_vec;
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      DEPKT_HOLD: begin
        if (out_eod) begin
          ld      = 1'b1;
          state_n = DEPKT_IDLE;
          idx_n   = '0;
        end
      end
      default: state_n = DEPKT_IDLE;
    endcase
    // completed packet goes straight to the output stage or waits in the assembly buffer
    if (done) begin
      idx_n = '0;
      if (out_eod) begin
        ld      = 1'b1;
        ld_vec  = done_vec;
        ld_vc   = done_vc;
        state_n = DEPKT_IDLE;
      end else begin
        asm_n   = done_vec;
        vc_n    = done_vc;
        state_n = DEPKT_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DEPKT_IDLE;
      idx      <= '0;
      assembly <= '0;
      vc_r     <= '0;
      err_out  <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      assembly <= asm_n;
      vc_r     <= vc_n;
      err_out  <= err_n;
    end
  end

  assign ld_word = {ld_vc, WIDTH_DATA'(ld_vec >> (CAP_BITS - WIDTH_DATA))};

  depkt_out_reg #(.W(OUT_W)) u_out_reg (
    .clk               (clk),
    .rst_n             (rst_n),
    .load              (ld),
    .load_data         (ld_word),
    .ready_in          (ready_in),
    .valid_out         (valid_out),
    .data_out          (out_word),
    .empty_or_draining (out_eod)
  );

  assign {vc_out, data_out} = out_word;

endmodule
